// File: rtl/sp_mem_ctrl.sv
// Single-port word memory behind a valid/ready request port with byte strobes,
// registered reads, write-data loopback and an out-of-range trap state.
module sp_mem_ctrl #(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned DEPTH         = 12,
  parameter int unsigned ADDR_WIDTH    = 4,
  parameter int unsigned ERR_CNT_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      rd_wr,
  input  logic [ADDR_WIDTH-1:0]     addr,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  input  logic [DATA_WIDTH/8-1:0]   wr_be,
  input  logic                      out_wr_data_en,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic                      rd_valid,
  output logic [DATA_WIDTH-1:0]     out_wr_data,
  output logic                      error,
  output logic [ADDR_WIDTH-1:0]     err_addr,
  output logic [ERR_CNT_WIDTH-1:0]  err_cnt,
  input  logic                      err_clr
);

  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
  // One extra bit so DEPTH == 2**ADDR_WIDTH is representable and never traps.
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

  state_t                     state_q, state_d;
  logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
  logic [DATA_WIDTH-1:0]      wr_data_q, wr_data_d;
  logic [BE_WIDTH-1:0]        wr_be_q, wr_be_d;
  logic [DATA_WIDTH-1:0]      rd_data_q, rd_data_d;
  logic                       rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0]      out_wr_data_q, out_wr_data_d;
  logic                       error_q, error_d;
  logic [ADDR_WIDTH-1:0]      err_addr_q, err_addr_d;
  logic [ERR_CNT_WIDTH-1:0]   err_cnt_q, err_cnt_d;
  logic                       req_ready_q, req_ready_d;

  logic [DATA_WIDTH-1:0]      mem_q [DEPTH];
  logic                       mem_we_c;
  logic [DATA_WIDTH-1:0]      mem_wdata_c;
  logic                       in_range_c;

  assign in_range_c = ({1'b0, addr} < DEPTH_W);

  // Next-state and datapath decode.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wr_data_d     = wr_data_q;
    wr_be_d       = wr_be_q;
    rd_data_d     = rd_data_q;
    rd_valid_d    = 1'b0;
    out_wr_data_d = out_wr_data_q;
    error_d       = error_q;
    err_addr_d    = err_addr_q;
    err_cnt_d     = err_cnt_q;
    mem_we_c      = 1'b0;
    mem_wdata_c   = '0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d    = addr;
          wr_data_d = wr_data;
          wr_be_d   = wr_be;
          if (!in_range_c) begin
            state_d    = ST_ERROR;
            error_d    = 1'b1;
            err_addr_d = addr;
            if (err_cnt_q != '1) begin
              err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
            end
          end else if (rd_wr) begin
            state_d = ST_WRITE;
          end else begin
            state_d = ST_READ;
          end
        end
      end
      ST_WRITE: begin
        // Read-modify-write merge of the strobed bytes into the stored word.
        mem_we_c    = 1'b1;
        mem_wdata_c = mem_q[addr_q];
        for (int unsigned k = 0; k < BE_WIDTH; k++) begin
          if (wr_be_q[k]) begin
            mem_wdata_c[8*k +: 8] = wr_data_q[8*k +: 8];
          end
        end
        if (out_wr_data_en) begin
          out_wr_data_d = wr_data_q;
        end
        state_d = ST_IDLE;
      end
      ST_READ: begin
        rd_data_d  = mem_q[addr_q];
        rd_valid_d = 1'b1;
        state_d    = ST_IDLE;
      end
      ST_ERROR: begin
        if (err_clr) begin
          error_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    req_ready_d = (state_d == ST_IDLE);
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      wr_data_q     <= '0;
      wr_be_q       <= '0;
      rd_data_q     <= '0;
      rd_valid_q    <= 1'b0;
      out_wr_data_q <= '0;
      error_q       <= 1'b0;
      err_addr_q    <= '0;
      err_cnt_q     <= '0;
      req_ready_q   <= 1'b1;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wr_data_q     <= wr_data_d;
      wr_be_q       <= wr_be_d;
      rd_data_q     <= rd_data_d;
      rd_valid_q    <= rd_valid_d;
      out_wr_data_q <= out_wr_data_d;
      error_q       <= error_d;
      err_addr_q    <= err_addr_d;
      err_cnt_q     <= err_cnt_d;
      req_ready_q   <= req_ready_d;
    end
  end

  // Storage array; reset wipes every word and cancels a pending write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we_c) begin
      mem_q[addr_q] <= mem_wdata_c;
    end
  end

  assign req_ready   = req_ready_q;
  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign out_wr_data = out_wr_data_q;
  assign error       = error_q;
  assign err_addr    = err_addr_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_sp_mem_ctrl.sv
// Self-checking bench for sp_mem_ctrl: directed vector table, trap/reset
// sequences and randomized traffic against a transaction-level model.
module tb_sp_mem_ctrl;

  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 12;
  localparam int unsigned AW    = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          rd_wr;
  logic [AW-1:0] addr;
  logic [DW-1:0] wr_data;
  logic [1:0]    wr_be;
  logic          out_wr_data_en;
  logic          err_clr;

  logic          req_ready, rd_valid, error;
  logic [DW-1:0] rd_data, out_wr_data;
  logic [AW-1:0] err_addr;
  logic [7:0]    err_cnt;

  logic          req_ready2, rd_valid2, error2;
  logic [DW-1:0] rd_data2, out_wr_data2;
  logic [AW-1:0] err_addr2;
  logic [1:0]    err_cnt2;

  always #5 clk = ~clk;

  sp_mem_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .ERR_CNT_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .rd_wr(rd_wr), .addr(addr), .wr_data(wr_data), .wr_be(wr_be),
    .out_wr_data_en(out_wr_data_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .out_wr_data(out_wr_data), .error(error), .err_addr(err_addr),
    .err_cnt(err_cnt), .err_clr(err_clr)
  );

  // Same traffic, narrow counter to observe saturation at 3.
  sp_mem_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .ERR_CNT_WIDTH(2)) dut2 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready2),
    .rd_wr(rd_wr), .addr(addr), .wr_data(wr_data), .wr_be(wr_be),
    .out_wr_data_en(out_wr_data_en), .rd_data(rd_data2), .rd_valid(rd_valid2),
    .out_wr_data(out_wr_data2), .error(error2), .err_addr(err_addr2),
    .err_cnt(err_cnt2), .err_clr(err_clr)
  );

  // Transaction-level model.
  logic [DW-1:0] mem_m [DEPTH];
  logic [DW-1:0] rd_m, owd_m;
  logic          err_m;
  logic [AW-1:0] err_addr_m;
  int            cnt_m;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          rw;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [1:0]    be;
    logic          lb;
    logic [DW-1:0] exp_rd;
    logic [DW-1:0] exp_owd;
  } vec_t;

  vec_t tbl [10];

  function automatic logic [31:0] sat(input int c, input int m);
    return (c > m) ? 32'(m) : 32'(c);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(DEPTH); i++) mem_m[i] = '0;
    rd_m = '0; owd_m = '0; err_m = 1'b0; err_addr_m = '0; cnt_m = 0;
  endtask

  task automatic check_all(input string tag, input logic exp_ready, input logic exp_rv);
    chk({tag, ".req_ready"},    32'(req_ready),    32'(exp_ready));
    chk({tag, ".rd_valid"},     32'(rd_valid),     32'(exp_rv));
    chk({tag, ".rd_data"},      32'(rd_data),      32'(rd_m));
    chk({tag, ".out_wr_data"},  32'(out_wr_data),  32'(owd_m));
    chk({tag, ".error"},        32'(error),        32'(err_m));
    chk({tag, ".err_addr"},     32'(err_addr),     32'(err_addr_m));
    chk({tag, ".err_cnt"},      32'(err_cnt),      sat(cnt_m, 255));
    chk({tag, ".req_ready2"},   32'(req_ready2),   32'(exp_ready));
    chk({tag, ".rd_valid2"},    32'(rd_valid2),    32'(exp_rv));
    chk({tag, ".rd_data2"},     32'(rd_data2),     32'(rd_m));
    chk({tag, ".out_wr_data2"}, 32'(out_wr_data2), 32'(owd_m));
    chk({tag, ".error2"},       32'(error2),       32'(err_m));
    chk({tag, ".err_addr2"},    32'(err_addr2),    32'(err_addr_m));
    chk({tag, ".err_cnt2"},     32'(err_cnt2),     sat(cnt_m, 3));
  endtask

  task automatic wait_ready();
    int n = 0;
    while (req_ready !== 1'b1 && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready_wait", 32'(req_ready), 32'd1);
  endtask

  // One request from accept to completion; inputs are scrambled after accept.
  task automatic do_req(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [1:0] be, input logic lb);
    wait_ready();
    req_valid = 1'b1; rd_wr = rw; addr = a; wr_data = d; wr_be = be;
    @(posedge clk); #1;
    req_valid = 1'b0; rd_wr = 1'($urandom); addr = 4'($urandom);
    wr_data = 16'($urandom); wr_be = 2'($urandom); out_wr_data_en = lb;
    if (32'(a) >= DEPTH) begin
      err_m = 1'b1; err_addr_m = a; cnt_m++;
      check_all("trap", 1'b0, 1'b0);
    end else if (rw) begin
      check_all("write_busy", 1'b0, 1'b0);
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) if (be[k]) mem_m[a][8*k +: 8] = d[8*k +: 8];
      if (lb) owd_m = d;
      out_wr_data_en = 1'($urandom);
      check_all("write_done", 1'b1, 1'b0);
    end else begin
      check_all("read_busy", 1'b0, 1'b0);
      @(posedge clk); #1;
      rd_m = mem_m[a];
      out_wr_data_en = 1'($urandom);
      check_all("read_done", 1'b1, 1'b1);
    end
  endtask

  task automatic hold_error(input int n);
    req_valid = 1'b1; rd_wr = 1'b1; addr = 4'd2; wr_data = 16'h7777; wr_be = 2'b11;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check_all("err_hold", 1'b0, 1'b0);
    end
    req_valid = 1'b0;
  endtask

  task automatic clear_err(input logic with_req);
    err_clr = 1'b1; req_valid = with_req; rd_wr = 1'b1; addr = 4'd2;
    wr_data = 16'hBAD0; wr_be = 2'b11;
    @(posedge clk); #1;
    err_clr = 1'b0; req_valid = 1'b0;
    err_m = 1'b0;
    check_all("clear", 1'b1, 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b0, 4'd3,  16'h0000, 2'b00, 1'b0, 16'h0000, 16'h0000};
    tbl[1] = '{1'b1, 4'd5,  16'hA5C3, 2'b11, 1'b1, 16'h0000, 16'hA5C3};
    tbl[2] = '{1'b0, 4'd5,  16'h0000, 2'b00, 1'b0, 16'hA5C3, 16'hA5C3};
    tbl[3] = '{1'b1, 4'd7,  16'h1234, 2'b11, 1'b0, 16'hA5C3, 16'hA5C3};
    tbl[4] = '{1'b1, 4'd7,  16'hFF00, 2'b10, 1'b1, 16'hA5C3, 16'hFF00};
    tbl[5] = '{1'b0, 4'd7,  16'h0000, 2'b00, 1'b0, 16'hFF34, 16'hFF00};
    tbl[6] = '{1'b1, 4'd7,  16'h5555, 2'b00, 1'b0, 16'hFF34, 16'hFF00};
    tbl[7] = '{1'b0, 4'd7,  16'h0000, 2'b00, 1'b0, 16'hFF34, 16'hFF00};
    tbl[8] = '{1'b1, 4'd11, 16'hCAFE, 2'b01, 1'b1, 16'hFF34, 16'hCAFE};
    tbl[9] = '{1'b0, 4'd11, 16'h0000, 2'b00, 1'b0, 16'h00FE, 16'hCAFE};

    reset = 1'b1; req_valid = 1'b0; rd_wr = 1'b0; addr = '0; wr_data = '0;
    wr_be = '0; out_wr_data_en = 1'b0; err_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check_all("reset", 1'b1, 1'b0);

    // Directed vectors.
    for (int i = 0; i < 10; i++) begin
      do_req(tbl[i].rw, tbl[i].a, tbl[i].d, tbl[i].be, tbl[i].lb);
      chk($sformatf("tbl%0d.rd_data", i), 32'(rd_data), 32'(tbl[i].exp_rd));
      chk($sformatf("tbl%0d.out_wr_data", i), 32'(out_wr_data), 32'(tbl[i].exp_owd));
    end

    // Trap on addr 13, ignored requests, clear racing a request.
    do_req(1'b1, 4'd13, 16'hDEAD, 2'b11, 1'b1);
    chk("trap13.err_addr", 32'(err_addr), 32'd13);
    chk("trap13.err_cnt", 32'(err_cnt), 32'd1);
    hold_error(3);
    clear_err(1'b1);
    chk("clr13.err_addr", 32'(err_addr), 32'd13);
    chk("clr13.error", 32'(error), 32'd0);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    check_all("clr_idle", 1'b1, 1'b0);
    do_req(1'b0, 4'd2, 16'h0, 2'b00, 1'b0);
    chk("after_trap.mem2", 32'(rd_data), 32'h0);

    // Saturation of the narrow counter.
    do_req(1'b0, 4'd12, 16'h1111, 2'b11, 1'b0); clear_err(1'b0);
    do_req(1'b1, 4'd14, 16'h2222, 2'b11, 1'b1); clear_err(1'b1);
    do_req(1'b1, 4'd15, 16'h3333, 2'b01, 1'b0); clear_err(1'b0);
    chk("sat.err_cnt2", 32'(err_cnt2), 32'd3);
    chk("sat.err_cnt", 32'(err_cnt), 32'd4);
    chk("sat.err_addr", 32'(err_addr), 32'd15);

    // Reset lands on the WRITE cycle: write must be dropped.
    wait_ready();
    req_valid = 1'b1; rd_wr = 1'b1; addr = 4'd2; wr_data = 16'hBEEF; wr_be = 2'b11;
    @(posedge clk); #1;
    req_valid = 1'b0; out_wr_data_en = 1'b1; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; out_wr_data_en = 1'b0;
    model_reset();
    check_all("post_reset", 1'b1, 1'b0);
    do_req(1'b0, 4'd2, 16'h0, 2'b00, 1'b0);
    chk("post_reset.mem2", 32'(rd_data), 32'h0);

    // Randomized traffic.
    for (int t = 0; t < 300; t++) begin
      logic [AW-1:0] a;
      a = (($urandom % 8) == 0) ? 4'($urandom_range(12, 15)) : 4'($urandom_range(0, 11));
      if (($urandom % 4) == 0) begin
        out_wr_data_en = 1'($urandom);
        err_clr = 1'($urandom);
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1 err_clr = 1'b0;
        check_all("idle_gap", 1'b1, 1'b0);
      end
      do_req(1'($urandom), a, 16'($urandom), 2'($urandom), 1'($urandom));
      if (32'(a) >= DEPTH) begin
        hold_error($urandom_range(0, 2));
        clear_err(1'($urandom));
      end
    end

    // Final sweep of every implemented word.
    for (int i = 0; i < int'(DEPTH); i++) begin
      do_req(1'b0, 4'(i), 16'h0, 2'b00, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sp_mem_ctrl.md
Name: sp_mem_ctrl

Overview:
Parametrised synchronous single-port memory with a valid/ready request interface, per-byte write strobes, registered read with a valid pulse, and optional write-data loopback. Out-of-range addresses trap the block in an ERROR state with the offending address captured; software recovers through err_clr without reset. It is the general-purpose successor of the fixed 16x16 single-port memory and sits between register/bus logic and local storage.

Parameters:
DATA_WIDTH, 16, word width in bits; must be a multiple of 8.
DEPTH, 12, number of implemented words; must satisfy 1 <= DEPTH <= 2**ADDR_WIDTH.
ADDR_WIDTH, 4, address bus width.
ERR_CNT_WIDTH, 8, width of the saturating error counter.

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request (high only in IDLE)
rd_wr  in  1  1 = write, 0 = read
addr  in  ADDR_WIDTH  word address
wr_data  in  DATA_WIDTH  write data
wr_be  in  DATA_WIDTH/8  byte write enables, bit k -> wr_data[8k+7:8k]
out_wr_data_en  in  1  loopback enable for write data
rd_data  out  DATA_WIDTH  registered read data
rd_valid  out  1  one-cycle pulse, rd_data updated
out_wr_data  out  DATA_WIDTH  looped-back write data
error  out  1  out-of-range trap flag
err_addr  out  ADDR_WIDTH  address that caused the trap
err_cnt  out  ERR_CNT_WIDTH  saturating count of traps
err_clr  in  1  leave ERROR without reset

Behaviour:
- Reset (sampled at clk edge while reset=1): state=IDLE; rd_data, out_wr_data, err_addr, err_cnt = 0; rd_valid, error = 0; all DEPTH words cleared to 0. Reset overrides any in-flight operation; a write in WRITE state at that edge is not committed.
- States: IDLE, WRITE, READ, ERROR. req_ready = (state == IDLE), purely decoded from state.
- IDLE: on req_valid & req_ready, register addr, wr_data, wr_be and rd_wr. Next state: if addr >= DEPTH -> ERROR (error<=1, err_addr<=addr, err_cnt<=err_cnt+1, saturating at all-ones); else rd_wr=1 -> WRITE, rd_wr=0 -> READ. Range check takes priority over operation type. No request -> stay IDLE.
- WRITE (1 cycle): for each k with captured wr_be[k]=1, mem[addr_q] byte k <= wr_data_q byte k; other bytes unchanged; wr_be all-zero is a legal no-op write. If out_wr_data_en=1 in this cycle, out_wr_data <= full wr_data_q (unmasked); else out_wr_data holds. -> IDLE.
- READ (1 cycle): rd_data <= mem[addr_q]; rd_valid=1 for exactly the following cycle. -> IDLE. rd_data holds between reads.
- Latency: request accepted at edge N; write visible at edge N+1; read data and rd_valid valid after edge N+1. Peak throughput one request per 2 cycles. A read issued right after a write to the same address returns the new data.
- ERROR: req_ready=0, requests are not accepted and not queued. err_clr=1 -> IDLE and error<=0 at the same edge; err_addr and err_cnt hold. err_clr outside ERROR is ignored. err_clr and req_valid in the same ERROR cycle: only the clear takes effect.
- Memory contents are never modified by an out-of-range request.
- When DEPTH = 2**ADDR_WIDTH, ERROR is unreachable; error stays 0.

Test Plan:
- Reset, then read addr 3 -> rd_valid pulses 2 cycles after req accept edge... precisely one cycle after the READ edge, rd_data=0x0000; req_ready low during READ.
- Write 0xA5C3 to addr 5 with wr_be=2'b11 and out_wr_data_en=1, then read addr 5 -> out_wr_data=0xA5C3, rd_data=0xA5C3.
- Write 0x1234 to addr 7 (be=11), then write 0xFF00 with be=2'b10, read -> rd_data=0xFF34; a be=00 write leaves 0xFF34.
- DEPTH=12: request to addr 13 -> error=1, err_addr=13, err_cnt=1, req_ready=0; further req_valid ignored; err_clr -> IDLE, error=0, err_addr still 13; addr 13 contents unchanged.
- Assert reset during WRITE state of write 0xBEEF to addr 2 -> after reset mem[2]=0, all outputs at reset values, state IDLE.
- ERR_CNT_WIDTH=2: four out-of-range traps with clears between -> err_cnt saturates at 3.
